// File: rtl/vm_read_arbiter_pkg.sv
// Shared types and constants for the video-memory read arbiter.
// Holds the FSM state encoding, the histogram-select bit position and a saturating counter helper.
package vm_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE,
        GAP
    } arb_state_t;

    // Downstream, this address bit selects histogram (1) or line (0) memory
    localparam int VM_HISTO_SEL_BIT = 9;

    localparam logic [7:0] ERR_COUNT_MAX = 8'hFF;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == ERR_COUNT_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/vm_read_arbiter_if.sv
// Bundles the requester-side handshake and the vm_* line-reader bus.
// The master modport is the arbiter's view; slave is the requesters' and line reader's view.
interface vm_read_arbiter_if
    import vm_arb_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64
);

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ-1:0]        req_ack;
    logic                    req_err;
    logic [DATA_W-1:0]       req_rdata;

    logic [ADDR_W-1:0]       vm_address;
    logic                    vm_bus_enable;
    logic                    vm_rw;
    logic                    vm_acknowledge;
    logic [DATA_W-1:0]       vm_read_data;

    modport master (
        input  req_valid, req_addr, vm_acknowledge, vm_read_data,
        output req_ack, req_err, req_rdata, vm_address, vm_bus_enable, vm_rw
    );

    modport slave (
        output req_valid, req_addr, vm_acknowledge, vm_read_data,
        input  req_ack, req_err, req_rdata, vm_address, vm_bus_enable, vm_rw
    );

endinterface

// File: rtl/vm_read_arbiter_rr_pick.sv
// Combinational round-robin selector: first valid requester searching upward from last_grant+1.
module rr_pick
    import vm_arb_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int GW    = 1
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [GW-1:0]    last_grant,
    output logic [GW-1:0]    grant,
    output logic             valid
);

    logic [GW-1:0] idx;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            idx = GW'((32'(last_grant) + i) % N_REQ);
            if (!valid && req_valid[idx]) begin
                grant = idx;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vm_read_arbiter.sv
// Round-robin arbiter sharing the single vm_* read port between N_REQ requesters,
// with a per-transaction acknowledge timeout and a guaranteed idle gap between transactions.
module vm_read_arbiter
    import vm_arb_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    vm_read_arbiter_if.master    bus,
    output logic                 busy,
    output logic [7:0]           err_count
);

    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    arb_state_t          state_q, state_d;
    logic [GW-1:0]       grant_q, grant_d;
    logic [GW-1:0]       last_grant_q, last_grant_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [N_REQ-1:0]    req_ack_q, req_ack_d;
    logic                req_err_q, req_err_d;
    logic [DATA_W-1:0]   req_rdata_q, req_rdata_d;
    logic [ADDR_W-1:0]   vm_addr_q, vm_addr_d;
    logic                vm_en_q, vm_en_d;
    logic                vm_rw_q;
    logic                busy_q, busy_d;
    logic [7:0]          err_cnt_q, err_cnt_d;

    logic [GW-1:0]       pick_grant;
    logic                pick_valid;
    logic [ADDR_W-1:0]   sel_addr;
    logic [N_REQ-1:0]    grant_onehot;

    rr_pick #(
        .N_REQ (N_REQ),
        .GW    (GW)
    ) u_rr_pick (
        .req_valid  (bus.req_valid),
        .last_grant (last_grant_q),
        .grant      (pick_grant),
        .valid      (pick_valid)
    );

    always_comb begin
        sel_addr     = '0;
        grant_onehot = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (GW'(i) == pick_grant) begin
                sel_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
            end
            grant_onehot[i] = (GW'(i) == grant_q);
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        timer_d      = timer_q;
        req_ack_d    = '0;
        req_err_d    = req_err_q;
        req_rdata_d  = req_rdata_q;
        vm_addr_d    = vm_addr_q;
        vm_en_d      = vm_en_q;
        err_cnt_d    = err_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d   = pick_grant;
                    vm_addr_d = sel_addr;
                    vm_en_d   = 1'b1;
                    timer_d   = '0;
                    state_d   = REQ;
                end
            end
            REQ: begin
                timer_d = timer_q + 1'b1;
                // The ack pulse is registered here so it is visible during the DONE cycle
                if (bus.vm_acknowledge) begin
                    req_rdata_d = bus.vm_read_data;
                    req_err_d   = 1'b0;
                    vm_en_d     = 1'b0;
                    req_ack_d   = grant_onehot;
                    state_d     = DONE;
                end else if (timer_q == TW'(TIMEOUT)) begin
                    req_rdata_d = '0;
                    req_err_d   = 1'b1;
                    err_cnt_d   = sat_inc8(err_cnt_q);
                    vm_en_d     = 1'b0;
                    req_ack_d   = grant_onehot;
                    state_d     = DONE;
                end
            end
            DONE: begin
                last_grant_d = grant_q;
                state_d      = GAP;
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(N_REQ - 1);
            timer_q      <= '0;
            req_ack_q    <= '0;
            req_err_q    <= 1'b0;
            req_rdata_q  <= '0;
            vm_addr_q    <= '0;
            vm_en_q      <= 1'b0;
            vm_rw_q      <= 1'b1;
            busy_q       <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            timer_q      <= timer_d;
            req_ack_q    <= req_ack_d;
            req_err_q    <= req_err_d;
            req_rdata_q  <= req_rdata_d;
            vm_addr_q    <= vm_addr_d;
            vm_en_q      <= vm_en_d;
            vm_rw_q      <= 1'b1;
            busy_q       <= busy_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign bus.req_ack       = req_ack_q;
    assign bus.req_err       = req_err_q;
    assign bus.req_rdata     = req_rdata_q;
    assign bus.vm_address    = vm_addr_q;
    assign bus.vm_bus_enable = vm_en_q;
    assign bus.vm_rw         = vm_rw_q;
    assign busy              = busy_q;
    assign err_count         = err_cnt_q;

endmodule

// File: tb/tb_vm_read_arbiter.sv
// Directed bench for vm_read_arbiter: scoreboard of expected completions plus a simple line-reader model.
module tb_vm_read_arbiter;
    import vm_arb_pkg::*;

    localparam int N_REQ   = 2;
    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 64;
    localparam int TIMEOUT = 15;

    localparam logic [ADDR_W-1:0] A_SINGLE = 10'h005;
    localparam logic [ADDR_W-1:0] A_RR0    = 10'h010;
    localparam logic [ADDR_W-1:0] A_RR1    = 10'(32'h010 | (32'd1 << VM_HISTO_SEL_BIT));
    localparam logic [ADDR_W-1:0] A_TO     = 10'h020;
    localparam logic [ADDR_W-1:0] A_MID    = 10'h033;

    typedef struct {
        int                idx;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        busy;
    logic [7:0]  err_count;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    vm_read_arbiter_if #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    vm_read_arbiter #(
        .N_REQ   (N_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .busy      (busy),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] data_for(input logic [ADDR_W-1:0] a);
        return 64'h1122334455667783 + 64'(a);
    endfunction

    // Line-reader model: one-cycle ack pulse, one cycle after it sees enable
    logic              model_ack    = 1'b0;
    logic [DATA_W-1:0] model_data   = '0;
    logic              model_ack_en = 1'b1;
    logic              spur_ack     = 1'b0;
    logic [DATA_W-1:0] spur_mask    = '0;

    always @(posedge clk) begin
        model_ack  <= model_ack_en && bus.vm_bus_enable && !model_ack;
        model_data <= data_for(bus.vm_address);
    end

    assign bus.vm_acknowledge = model_ack | spur_ack;
    assign bus.vm_read_data   = model_data ^ spur_mask;

    // Bus monitor: enable run lengths, gaps between enable bursts, ack pulse counts
    int   en_run = 0, en_run_max = 0, low_run = 0, min_gap = 1000;
    int   ack_pulses = 0, ack_bad = 0;
    logic en_prev = 1'b0, seen_high = 1'b0, mon_clear = 1'b0;

    initial forever begin
        @(posedge clk);
        #1;
        if (bus.req_ack != '0) begin
            ack_pulses++;
            if (!$onehot(bus.req_ack)) ack_bad++;
        end
        if (mon_clear) begin
            en_run = 0; en_run_max = 0; low_run = 0; min_gap = 1000;
            seen_high = 1'b0; en_prev = 1'b0;
        end else begin
            if (bus.vm_bus_enable) begin
                if (!en_prev && seen_high && low_run < min_gap) min_gap = low_run;
                en_run++;
                if (en_run > en_run_max) en_run_max = en_run;
                seen_high = 1'b1;
                low_run   = 0;
            end else begin
                en_run = 0;
                low_run++;
            end
            en_prev = bus.vm_bus_enable;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int idx, input logic v, input logic [ADDR_W-1:0] a);
        bus.req_valid[idx]                 = v;
        bus.req_addr[idx*ADDR_W +: ADDR_W] = a;
    endtask

    task automatic push(input int idx, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input logic e);
        exp_t x;
        x.idx = idx; x.addr = a; x.data = d; x.err = e;
        sb.push_back(x);
    endtask

    task automatic await_ack(input int budget, output int waited);
        waited = 0;
        while (waited < budget) begin
            @(negedge clk);
            waited++;
            if (bus.req_ack != '0) return;
        end
        checks++;
        assert (bus.req_ack != '0) else begin
            errors++;
            $error("FAIL ack_timeout: req_ack=%b after %0d cycles, expected a pulse", bus.req_ack, waited);
        end
    endtask

    task automatic check_pop(input string tag);
        exp_t e;
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL %s_sb: observed empty scoreboard expected a pending entry", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_ack"},   64'(bus.req_ack),    64'(1 << e.idx));
            check({tag, "_data"},  64'(bus.req_rdata),  64'(e.data));
            check({tag, "_err"},   64'(bus.req_err),    64'(e.err));
            check({tag, "_vaddr"}, 64'(bus.vm_address), 64'(e.addr));
        end
    endtask

    initial begin
        int n;
        bus.req_valid = '0;
        bus.req_addr  = '0;

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b1;
        check("rst_ack",    64'(bus.req_ack),       64'd0);
        check("rst_err",    64'(bus.req_err),       64'd0);
        check("rst_rdata",  64'(bus.req_rdata),     64'd0);
        check("rst_en",     64'(bus.vm_bus_enable), 64'd0);
        check("rst_addr",   64'(bus.vm_address),    64'd0);
        check("rst_rw",     64'(bus.vm_rw),         64'd1);
        check("rst_busy",   64'(busy),              64'd0);
        check("rst_errcnt", 64'(err_count),         64'd0);

        // Single read with immediate acknowledge
        @(negedge clk);
        set_req(0, 1'b1, A_SINGLE);
        push(0, A_SINGLE, 64'h1122334455667788, 1'b0);
        @(negedge clk);
        check("single_en",   64'(bus.vm_bus_enable), 64'd1);
        check("single_addr", 64'(bus.vm_address),    64'(A_SINGLE));
        check("single_busy", 64'(busy),              64'd1);
        await_ack(30, n);
        check("single_latency", 64'(n), 64'd2);
        check_pop("single");
        @(negedge clk);
        set_req(0, 1'b0, A_SINGLE);
        check("single_gap1", 64'(bus.vm_bus_enable), 64'd0);
        @(negedge clk);
        check("single_gap2", 64'(bus.vm_bus_enable), 64'd0);
        check("single_idle", 64'(busy),              64'd0);

        // Back-to-back contention after a fresh reset: strict alternation
        rst = 1'b0;
        mon_clear = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        mon_clear = 1'b0;
        set_req(0, 1'b1, A_RR0);
        set_req(1, 1'b1, A_RR1);
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) push(0, A_RR0, data_for(A_RR0), 1'b0);
            else            push(1, A_RR1, data_for(A_RR1), 1'b0);
        end
        for (int k = 0; k < 6; k++) begin
            await_ack(30, n);
            check("rr_spacing", 64'(n), (k == 0) ? 64'd3 : 64'd5);
            check_pop("rr");
        end
        @(negedge clk);
        set_req(0, 1'b0, A_RR0);
        set_req(1, 1'b0, A_RR1);
        check("rr_min_gap", 64'(min_gap), 64'd3);
        check("rr_ack_onehot", 64'(ack_bad), 64'd0);

        // Acknowledge never arrives: timeout completion, then saturation
        model_ack_en = 1'b0;
        mon_clear = 1'b1;
        @(negedge clk);
        mon_clear = 1'b0;
        set_req(0, 1'b1, A_TO);
        push(0, A_TO, '0, 1'b1);
        await_ack(40, n);
        check("to_latency", 64'(n), 64'd17);
        check_pop("to");
        check("to_en_len", 64'(en_run_max), 64'(TIMEOUT + 1));
        check("to_errcnt", 64'(err_count),  64'd1);
        for (int k = 2; k <= 256; k++) begin
            push(0, A_TO, '0, 1'b1);
            await_ack(40, n);
            check("to_spacing", 64'(n), 64'd19);
            check_pop("to_sat");
            check("to_sat_errcnt", 64'(err_count), (k > 255) ? 64'd255 : 64'(k));
        end
        @(negedge clk);
        set_req(0, 1'b0, A_TO);

        // Reset asserted mid-transaction abandons it
        repeat (3) @(negedge clk);
        set_req(1, 1'b1, A_MID);
        repeat (3) @(negedge clk);
        check("mid_en",   64'(bus.vm_bus_enable), 64'd1);
        check("mid_addr", 64'(bus.vm_address),    64'(A_MID));
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_en",     64'(bus.vm_bus_enable), 64'd0);
        check("mid_rst_ack",    64'(bus.req_ack),       64'd0);
        check("mid_rst_busy",   64'(busy),              64'd0);
        check("mid_rst_errcnt", 64'(err_count),         64'd0);
        model_ack_en = 1'b1;
        rst = 1'b1;
        push(1, A_MID, data_for(A_MID), 1'b0);
        await_ack(30, n);
        check("mid_latency", 64'(n), 64'd3);
        check_pop("mid");
        @(negedge clk);
        set_req(1, 1'b0, A_MID);

        // Spurious acknowledge while idle is ignored
        repeat (3) @(negedge clk);
        spur_mask = '1;
        spur_ack  = 1'b1;
        @(negedge clk);
        spur_ack  = 1'b0;
        spur_mask = '0;
        check("spur_ack",   64'(bus.req_ack),       64'd0);
        check("spur_busy",  64'(busy),              64'd0);
        check("spur_en",    64'(bus.vm_bus_enable), 64'd0);
        check("spur_rdata", 64'(bus.req_rdata),     64'(data_for(A_MID)));
        check("spur_err",   64'(bus.req_err),       64'd0);
        @(negedge clk);
        check("spur_ack2",  64'(bus.req_ack),       64'd0);
        check("spur_busy2", 64'(busy),              64'd0);

        // Totals
        check("total_acks", 64'(ack_pulses), 64'd264);
        check("ack_onehot", 64'(ack_bad),    64'd0);
        check("sb_empty",   64'(sb.size()),  64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
